// File: rtl/controle_pipeline.sv
// controle_pipeline: registered MIPS control decoder (R-type group, LW, SW) with a
// valid/ready handshake, MUL occupancy and a load-use bubble enabled by CONTROLE_HAZARD_EN.
module controle_pipeline #(
    parameter int REG_W    = 5,
    parameter int GRUPO    = 14,
    parameter int MULT_LAT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           Instrucao,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  stall_in,
    output logic [10+3*REG_W-1:0] Controle,
    output logic                  ctrl_valid,
    output logic                  ilegal
);
    localparam int         CW       = 10 + 3*REG_W;
    localparam int         CNT_W    = $clog2(MULT_LAT + 1);
    localparam int         MULT_INI = (MULT_LAT > 1) ? MULT_LAT - 2 : 0;
    localparam logic [5:0] OP_R     = 6'(GRUPO);
    localparam logic [5:0] OP_LW    = 6'(GRUPO + 1);
    localparam logic [5:0] OP_SW    = 6'(GRUPO + 2);

    typedef enum logic [1:0] {EMITE, MULT, BOLHA} estado_t;

    typedef struct packed {
        logic       rw;
        logic [1:0] operacao;
        logic       offset;
        logic       entrada;
        logic       saida;
        logic       wb;
        logic       wr;
        logic       mult;
    } sinais_t;

    estado_t          r_state, w_next_state;
    logic [CNT_W-1:0] r_cnt, w_next_cnt;
    logic [CW-1:0]    r_ctrl;
    logic             r_valid, r_ilegal;
    logic [31:0]      r_held;

    logic [31:0]      w_instr;
    logic [5:0]       w_op, w_funct;
    logic [4:0]       w_shamt;
    logic [REG_W-1:0] w_rs, w_rt, w_rd;
    sinais_t          w_sig;
    logic             w_legal, w_is_mul;
    logic [CW-1:0]    w_word;
    logic             w_accept, w_issue, w_hazard;

    // A pending bubble decodes the held instruction instead of the bus.
    assign w_instr = (r_state == BOLHA) ? r_held : Instrucao;
    assign w_op    = w_instr[31:26];
    assign w_shamt = w_instr[10:6];
    assign w_funct = w_instr[5:0];
    assign w_rs    = REG_W'(w_instr >> 21);
    assign w_rt    = REG_W'(w_instr >> 16);

    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
        w_sig   = '0;
        w_legal = 1'b0;
        w_rd    = '0;
        if (w_op == OP_R && w_shamt == 5'd10) begin
            w_sig.rw = 1'b1;
            w_sig.wr = 1'b1;
            w_rd     = REG_W'(w_instr >> 11);
            w_legal  = 1'b1;
            case (w_funct)
                6'd32:   begin w_sig.operacao = 2'd0; w_sig.saida = 1'b1; end
                6'd34:   begin w_sig.operacao = 2'd1; w_sig.saida = 1'b1; end
                6'd36:   begin w_sig.operacao = 2'd2; w_sig.saida = 1'b1; end
                6'd37:   begin w_sig.operacao = 2'd3; w_sig.saida = 1'b1; end
                6'd50:   w_sig.mult = 1'b1;
                default: w_legal = 1'b0;
            endcase
        end else if (w_op == OP_LW) begin
            w_sig   = '{rw: 1'b1, operacao: 2'd0, offset: 1'b1, entrada: 1'b1,
                        saida: 1'b1, wb: 1'b1, wr: 1'b1, mult: 1'b0};
            w_rd    = w_rt;
            w_legal = 1'b1;
        end else if (w_op == OP_SW) begin
            w_sig   = '{rw: 1'b0, operacao: 2'd0, offset: 1'b1, entrada: 1'b1,
                        saida: 1'b1, wb: 1'b1, wr: 1'b0, mult: 1'b0};
            w_legal = 1'b1;
        end
    end

    // The spare MSB of the control word is always zero.
    assign w_word   = w_legal ? {1'b0, w_sig, w_rs, w_rt, w_rd} : '0;
    assign w_is_mul = w_legal & w_sig.mult;

    assign in_ready = !stall_in && (r_state == EMITE);
    assign w_accept = in_ready && in_valid;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_issue      = 1'b0;
        case (r_state)
            EMITE: begin
                if (w_accept) begin
                    if (w_hazard) w_next_state = BOLHA;
                    else          w_issue      = 1'b1;
                end
            end
            BOLHA: begin
                w_issue      = 1'b1;
                w_next_state = EMITE;
            end
            MULT: begin
                if (r_cnt == '0) w_next_state = EMITE;
                else             w_next_cnt   = r_cnt - CNT_W'(1);
            end
            default: w_next_state = EMITE;
        endcase
        if (w_issue && w_is_mul && MULT_LAT > 1) begin
            w_next_state = MULT;
            w_next_cnt   = CNT_W'(MULT_INI);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so every register samples pre-edge values.
        if (rst) begin
            r_state  <= EMITE;
            r_cnt    <= '0;
            r_ctrl   <= '0;
            r_valid  <= 1'b0;
            r_ilegal <= 1'b0;
            r_held   <= '0;
        end else if (!stall_in) begin
            r_state  <= w_next_state;
            r_cnt    <= w_next_cnt;
            r_ctrl   <= w_issue ? w_word : '0;
            r_valid  <= w_issue;
            r_ilegal <= w_issue && !w_legal;
            if (w_accept) r_held <= Instrucao;
        end
    end

`ifdef CONTROLE_HAZARD_EN
    logic [REG_W-1:0] r_lw_rd;
    logic             r_lw_vld;
    logic             w_uses_rt;

    assign w_uses_rt = (w_op == OP_R) || (w_op == OP_SW);

    // Only the instruction issued right behind an LW can need its data too early.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lw_vld <= 1'b0;
            r_lw_rd  <= '0;
        end else if (!stall_in) begin
            r_lw_vld <= w_issue && (w_op == OP_LW) && (w_rd != '0);
            r_lw_rd  <= w_rd;
        end
    end

    assign w_hazard = r_lw_vld && ((w_rs == r_lw_rd) || (w_uses_rt && (w_rt == r_lw_rd)));
`else
    assign w_hazard = 1'b0;
`endif

    assign Controle   = r_ctrl;
    assign ctrl_valid = r_valid;
    assign ilegal     = r_ilegal;
endmodule

// File: tb/tb_controle_pipeline.sv
// tb_controle_pipeline: randomized bench for controle_pipeline; a transaction-level
// model predicts Controle/ctrl_valid/ilegal/in_ready and is compared every cycle.
`timescale 1ns/1ps
module tb_controle_pipeline;
    localparam int REG_W    = 5;
    localparam int GRUPO    = 14;
    localparam int MULT_LAT = 3;
    localparam int CW       = 10 + 3*REG_W;
`ifdef CONTROLE_HAZARD_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, in_valid, stall_in;
    logic [31:0]   Instrucao;
    logic          in_ready, ctrl_valid, ilegal;
    logic [CW-1:0] Controle;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    controle_pipeline #(.REG_W(REG_W), .GRUPO(GRUPO), .MULT_LAT(MULT_LAT)) dut (
        .clk(clk), .rst(rst), .Instrucao(Instrucao), .in_valid(in_valid),
        .in_ready(in_ready), .stall_in(stall_in), .Controle(Controle),
        .ctrl_valid(ctrl_valid), .ilegal(ilegal)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Control word from the decode table: 9 control bits above Rs, Rt, Rd.
    function automatic void ref_decode(input logic [31:0] ins, output logic [CW-1:0] word,
                                       output bit ill, output bit mul, output int lw_rd);
        int op, rs, rt, rd, sh, fn, ctl;
        op = int'(ins[31:26]); rs = int'(ins[25:21]); rt = int'(ins[20:16]);
        rd = int'(ins[15:11]); sh = int'(ins[10:6]);  fn = int'(ins[5:0]);
        ctl = -1; lw_rd = 0; mul = 1'b0;
        if (op == GRUPO && sh == 10) begin
            if      (fn == 32) ctl = 256 + 0*64 + 8 + 2;
            else if (fn == 34) ctl = 256 + 1*64 + 8 + 2;
            else if (fn == 36) ctl = 256 + 2*64 + 8 + 2;
            else if (fn == 37) ctl = 256 + 3*64 + 8 + 2;
            else if (fn == 50) ctl = 256 + 2 + 1;
        end else if (op == GRUPO + 1) begin
            ctl = 256 + 32 + 16 + 8 + 4 + 2; rd = rt; lw_rd = rt;
        end else if (op == GRUPO + 2) begin
            ctl = 32 + 16 + 8 + 4; rd = 0;
        end
        ill = (ctl < 0);
        if (ill) word = '0;
        else begin
            word = CW'(ctl*32768 + rs*1024 + rt*32 + rd);
            mul  = (ctl == 259);
        end
    endfunction

    logic [CW-1:0] m_ctrl = '0;
    bit            m_valid = 1'b0, m_ilegal = 1'b0, m_known = 1'b0, m_pend = 1'b0;
    int            m_busy = 0, m_prev_rd = 0;
    logic [31:0]   m_pend_ins = '0;

    task automatic m_issue(input logic [31:0] ins);
        bit mul;
        ref_decode(ins, m_ctrl, m_ilegal, mul, m_prev_rd);
        m_valid = 1'b1;
        if (mul) m_busy = MULT_LAT - 1;
    endtask

    task automatic m_idle();
        m_ctrl = '0; m_valid = 1'b0; m_ilegal = 1'b0; m_prev_rd = 0;
    endtask

    // Inputs are stable from posedge+1 to the next posedge, so at the falling edge
    // the outputs are compared and the model is advanced to the coming rising edge.
    always @(negedge clk) begin
        bit dep;
        int op;
        if (m_known) begin
            check("Controle", 64'(Controle), 64'(m_ctrl));
            check("ctrl_valid", 64'(ctrl_valid), 64'(m_valid));
            check("ilegal", 64'(ilegal), 64'(m_ilegal));
            check("in_ready", 64'(in_ready), 64'(!stall_in && !m_pend && m_busy == 0));
        end
        if (rst) begin
            m_idle(); m_busy = 0; m_pend = 1'b0; m_known = 1'b1;
        end else if (!stall_in) begin
            op  = int'(Instrucao[31:26]);
            dep = HZ && m_prev_rd != 0 && (int'(Instrucao[25:21]) == m_prev_rd ||
                  ((op == GRUPO || op == GRUPO + 2) && int'(Instrucao[20:16]) == m_prev_rd));
            if (m_pend) begin
                m_issue(m_pend_ins); m_pend = 1'b0;
            end else if (m_busy > 0) begin
                m_busy--; m_idle();
            end else if (in_valid) begin
                if (dep) begin
                    m_pend = 1'b1; m_pend_ins = Instrucao; m_idle();
                end else m_issue(Instrucao);
            end else m_idle();
        end
    end

    function automatic logic [31:0] rand_instr();
        int          fl[5] = '{32, 34, 36, 37, 50};
        logic [4:0]  rs = 5'($urandom_range(0, 7));
        logic [4:0]  rt = 5'($urandom_range(0, 7));
        logic [4:0]  rd = 5'($urandom_range(0, 7));
        logic [15:0] imm = 16'($urandom);
        int          k = $urandom_range(0, 9);
        logic [5:0]  op;
        if (k <= 4) return {6'(GRUPO), rs, rt, rd, 5'd10, 6'(fl[k])};
        if (k == 5) return {6'(GRUPO + 1), rs, rt, imm};
        if (k == 6) return {6'(GRUPO + 2), rs, rt, imm};
        if (k == 7) begin
            op = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 13)) : 6'($urandom_range(17, 63));
            return {op, rs, rt, imm};
        end
        if (k == 8) return {6'(GRUPO), rs, rt, rd, 5'((10 + $urandom_range(1, 31)) % 32), 6'd32};
        return {6'(GRUPO), rs, rt, rd, 5'd10, 6'd33};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] ADD_I  = 32'h38221AA0;
    localparam logic [31:0] MUL_I  = {6'd14, 5'd1, 5'd2, 5'd3, 5'd10, 6'd50};
    localparam logic [31:0] LW_I   = 32'h3C850008;
    localparam logic [31:0] ADD2_I = {6'd14, 5'd5, 5'd2, 5'd3, 5'd10, 6'd32};
    localparam logic [31:0] SW_I   = {6'd16, 5'd4, 5'd6, 16'h0010};
    localparam logic [31:0] ILL_I  = 32'hFC000000;

    initial begin
        logic [CW-1:0] w;
        bit            ill, mul;
        int            lrd;

        ref_decode(ADD_I, w, ill, mul, lrd); check("model ADD", 64'(w), 64'h850443);
        ref_decode(MUL_I, w, ill, mul, lrd); check("model MUL", 64'(w), 64'h818443);
        ref_decode(LW_I, w, ill, mul, lrd);  check("model LW", 64'(w), 64'h9F10A5);
        ref_decode(ILL_I, w, ill, mul, lrd); check("model ilegal", 64'(ill), 64'd1);

        rst = 1'b1; in_valid = 1'b0; stall_in = 1'b0; Instrucao = '0;
        step(); step();
        rst = 1'b0;
        check("reset Controle", 64'(Controle), 64'd0);
        check("reset ctrl_valid", 64'(ctrl_valid), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);

        in_valid = 1'b1; Instrucao = ADD_I; step();
        check("ADD word", 64'(Controle), 64'h850443);
        check("ADD valid", 64'(ctrl_valid), 64'd1);
        check("ADD ilegal", 64'(ilegal), 64'd0);

        Instrucao = MUL_I; step();
        check("MUL word", 64'(Controle), 64'h818443);
        Instrucao = ADD_I;
        check("MUL ready 1", 64'(in_ready), 64'd0);
        step();
        check("MUL bubble valid", 64'(ctrl_valid), 64'd0);
        check("MUL ready 2", 64'(in_ready), 64'd0);
        step();
        check("MUL ready back", 64'(in_ready), 64'd1);
        step();
        check("ADD after MUL", 64'(Controle), 64'h850443);

        Instrucao = LW_I; step();
        check("LW word", 64'(Controle), 64'h9F10A5);
        Instrucao = ADD2_I; step();
`ifdef CONTROLE_HAZARD_EN
        check("load-use bubble valid", 64'(ctrl_valid), 64'd0);
        check("load-use bubble word", 64'(Controle), 64'd0);
        check("load-use ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0; Instrucao = '0; step();
`endif
        check("dependent ADD word", 64'(Controle), 64'h851443);
        check("dependent ADD valid", 64'(ctrl_valid), 64'd1);

        in_valid = 1'b1; Instrucao = ILL_I; step();
        check("ilegal word", 64'(Controle), 64'd0);
        check("ilegal valid", 64'(ctrl_valid), 64'd1);
        check("ilegal pulse", 64'(ilegal), 64'd1);
        in_valid = 1'b0; step();
        check("ilegal drop", 64'(ilegal), 64'd0);

        in_valid = 1'b1; Instrucao = SW_I; step();
        check("SW word", 64'(Controle), 64'h1E10C0);
        stall_in = 1'b1; Instrucao = ADD_I;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall ready", 64'(in_ready), 64'd0);
            step();
            check("stall hold", 64'(Controle), 64'h1E10C0);
        end
        stall_in = 1'b0; #1;
        check("stall release ready", 64'(in_ready), 64'd1);
        step();
        check("ADD after stall", 64'(Controle), 64'h850443);

        Instrucao = MUL_I; step();
        in_valid = 1'b0; rst = 1'b1; step(); step();
        rst = 1'b0;
        check("mid-MUL reset Controle", 64'(Controle), 64'd0);
        check("mid-MUL reset valid", 64'(ctrl_valid), 64'd0);
        check("mid-MUL reset ready", 64'(in_ready), 64'd1);

        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            stall_in  = ($urandom_range(0, 9) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            Instrucao = rand_instr();
            step();
        end
        rst = 1'b0; stall_in = 1'b0; in_valid = 1'b0;
        repeat (6) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/controle_pipeline.md
# controle_pipeline

Registered, parametrised successor to the combinational MIPS control decoder. Sits between the IF/ID register and the ID/EX register, and decodes group-14 R-type (ADD/SUB/AND/OR/MUL), LW and SW into the packed control word. It adds three behaviours: a valid/ready handshake, multi-cycle MUL occupancy, and load-use hazard bubble insertion. Rd, Rs and Rt field widths are generic.

## Interface
Parameters:
- REG_W, 5: register-index width; control word width CW = 10 + 3*REG_W.
- GRUPO, 14: R-type opcode; LW = GRUPO+1, SW = GRUPO+2.
- MULT_LAT, 3: cycles a MUL occupies the multiplier (≥1).

Ports:
- clk  in  1: single clock, rising edge.
- rst  in  1: reset; **synchronous and active-high**.
- Instrucao  in  32: instruction word.
- in_valid  in  1: Instrucao valid.
- in_ready  out  1: block accepts Instrucao this cycle.
- stall_in  in  1: downstream hold; freezes outputs.
- Controle  out  CW: {RW, Operacao[1:0], Habilitar_Offset, MUX_ALU_Entrada, MUX_ALU_Saida, MUX_WB, WR, Habilita_MULT, Rs, Rt, Rd}.
- ctrl_valid  out  1: Controle carries a real instruction.
- ilegal  out  1: pulse; the accepted instruction was undecodable.

## Operation
- Decode rules:
  - R-type with shamt=10: funct 32/34/36/37 → Operacao 0/1/2/3, MUX_ALU_Saida=1; funct 50 → Habilita_MULT=1, MUX_ALU_Saida=0.
  - R-type common fields: RW=1, WR=1, Rd=Instrucao[15:11].
  - LW: RW=1, Offset=1, Entrada=1, Saida=1, WB=1, WR=1, Rd=Rt.
  - SW: Offset=1, Entrada=1, Saida=1, WB=1, RW=0, WR=0, Rd=0.
- Any other opcode, or an R-type with another shamt/funct, decodes to an all-zero control word, ctrl_valid=1 and ilegal=1 for one cycle.
- Rs = Instrucao[21+:REG_W] and Rt = Instrucao[16+:REG_W], truncated/zero-padded to REG_W.
- FSM states:
  - EMITE: normal issue.
  - MULT: count down MULT_LAT-1 cycles, in_ready=0.
  - BOLHA: one bubble cycle.
- Transitions:
  - EMITE → MULT on an accepted MUL when MULT_LAT>1; MULT → EMITE when the count reaches 0.
  - EMITE → BOLHA on load-use (see Configuration); BOLHA → EMITE unconditionally.
- In BOLHA:
  - Controle is forced to 0 and ctrl_valid=0.
  - The stalled instruction is held internally and issued on the next cycle; it is not re-requested.
- In MULT: Controle and ctrl_valid go to 0 after the MUL's issue cycle.
- stall_in=1:
  - All registers hold and in_ready=0.
  - The FSM and counter freeze.
  - stall_in takes priority over every transition.

## Timing
- Reset (clk edge with rst=1):
  - Controle=0, ctrl_valid=0, ilegal=0; in_ready=1 the following cycle.
  - FSM=EMITE, counter=0, held instruction discarded.
  - Reset mid-MUL or mid-bubble aborts with no output.
- Latency: accept at edge N → Controle valid after edge N (registered, 1 cycle).
- Handshake: transfer when in_valid & in_ready; in_valid=0 → ctrl_valid=0 next cycle.
- in_ready is combinational from FSM state and stall_in only, never from Instrucao.
- MUL throughput: the next instruction is accepted MULT_LAT cycles after the MUL.
- Hazard: LW accepted at N, dependent instruction presented at N+1 → bubble on Controle at N+2, dependent control word at N+3.
- Simultaneous events:
  - A MUL that is also load-use dependent takes BOLHA first, then MULT.
  - rst overrides stall_in.

## Configuration
- CONTROLE_HAZARD_EN defined:
  - Last issued LW Rd (Rd≠0) is compared to the incoming Rs, and to Rt for R-type/SW.
  - A match enters BOLHA.
- Undefined:
  - No comparison logic; BOLHA is unreachable.
  - Dependent instructions issue back-to-back, and software guarantees spacing.

## Test plan
- Reset: rst=1 for 2 cycles mid-MUL → Controle=0, ctrl_valid=0, in_ready=1 one cycle after release.
- ADD 0x38221AA0 with in_valid=1 → next cycle Controle=0x850443, ctrl_valid=1, ilegal=0.
- MUL (funct 50, rs=1, rt=2, rd=3), MULT_LAT=3 → Habilita_MULT=1 and MUX_ALU_Saida=0 for one cycle; in_ready=0 for 2 cycles; next ADD accepted 3 cycles after the MUL.
- LW 0x3C850008 then ADD with rs=5, CONTROLE_HAZARD_EN defined:
  - LW word (Rd=5, WB=1) issues, then one bubble (ctrl_valid=0), then the ADD word.
  - With the macro undefined, the ADD follows the LW directly.
- Opcode 0x3F → Controle=0, ctrl_valid=1, ilegal pulse of 1 cycle.
- stall_in=1 for 3 cycles during a SW → Controle holds the SW word and in_ready=0; it resumes on the cycle stall_in drops.
